// File: rtl/sakebi_ipv4_packet_rx.sv
// sakebi_ipv4_packet_rx: byte-serial IPv4 header parser that forwards exactly the IPv4 payload.
// Define SAKEBI_IPV4_CSUM_CHECK_EN to also reject headers whose ones'-complement sum is not 16'hFFFF.
module sakebi_ipv4_packet_rx #(
    parameter int DATA_WIDTH    = 8,
    parameter int IP_ADDR_WIDTH = 32
) (
    input  logic                     i_axis_ACLK,
    input  logic                     i_axis_ARESET,
    input  logic                     i_axis_TVALID,
    output logic                     o_axis_TREADY,
    input  logic [DATA_WIDTH-1:0]    i_axis_TDATA,
    input  logic [15:0]              i_ethertype,
    output logic                     o_axis_TVALID,
    input  logic                     i_axis_TREADY,
    output logic [DATA_WIDTH-1:0]    o_axis_TDATA,
    output logic [IP_ADDR_WIDTH-1:0] o_src_ip_addr,
    output logic [IP_ADDR_WIDTH-1:0] o_dst_ip_addr,
    output logic [7:0]               o_protocol,
    output logic [15:0]              o_total_length,
    output logic                     o_hdr_valid,
    output logic                     o_hdr_err
);
    typedef enum logic [2:0] {IDLE, HEADER, OPTIONS, PAYLOAD, DROP} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [15:0]              r_cnt;
    logic [15:0]              r_rem;
    logic [7:0]               r_ver_ihl;
    logic [15:0]              r_tl;
    logic [7:0]               r_proto;
    logic [IP_ADDR_WIDTH-1:0] r_src;
    logic [IP_ADDR_WIDTH-1:0] r_dst;
    logic [IP_ADDR_WIDTH-1:0] w_dst;
    logic [15:0]              w_hlen;
    logic [15:0]              w_plen;
    logic                     w_bad;
    logic                     w_last;
    logic                     w_csum_bad;
    logic                     w_fwd;
    logic                     w_accept;
    logic                     w_err;
    logic                     w_unused_tready;

    assign o_axis_TREADY   = 1'b1;
    assign w_unused_tready = i_axis_TREADY;

    assign w_hlen = {10'd0, r_ver_ihl[3:0], 2'b00};
    assign w_plen = r_tl - w_hlen;
    assign w_bad  = (r_ver_ihl[7:4] != 4'd4) || (r_ver_ihl[3:0] < 4'd5) || (r_tl < w_hlen);
    assign w_last = (r_state == HEADER && r_cnt == 16'd19 && r_ver_ihl[3:0] == 4'd5) ||
                    (r_state == OPTIONS && r_cnt == w_hlen - 16'd1);
    // With IHL=5 the last destination byte is still on the input when the header is accepted
    assign w_dst  = (r_state == HEADER) ? {r_dst[IP_ADDR_WIDTH-DATA_WIDTH-1:0], i_axis_TDATA} : r_dst;

`ifdef SAKEBI_IPV4_CSUM_CHECK_EN
    logic [7:0]  r_hi;
    logic [15:0] r_csum;
    logic [16:0] w_sum_raw;
    logic [15:0] w_csum_nxt;

    assign w_sum_raw  = {1'b0, r_csum} + {1'b0, r_hi, i_axis_TDATA};
    assign w_csum_nxt = w_sum_raw[15:0] + {15'd0, w_sum_raw[16]};
    assign w_csum_bad = (w_csum_nxt != 16'hFFFF);

    // Even header bytes wait in r_hi; each odd byte completes a 16-bit word
    always_ff @(posedge i_axis_ACLK) begin
        if (i_axis_ARESET) begin
            r_hi   <= 8'd0;
            r_csum <= 16'd0;
        end else if (r_state == IDLE) begin
            r_hi   <= i_axis_TDATA;
            r_csum <= 16'd0;
        end else if (r_state == HEADER || r_state == OPTIONS) begin
            if (r_cnt[0]) r_csum <= w_csum_nxt;
            else r_hi <= i_axis_TDATA;
        end
    end
`else
    assign w_csum_bad = 1'b0;
`endif

    always_ff @(posedge i_axis_ACLK) begin
        if (i_axis_ARESET) r_state <= DROP;
        else r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = 1'b0;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: if (i_axis_TVALID) w_state_nxt = (i_ethertype == 16'h0800) ? HEADER : DROP;
            HEADER, OPTIONS: begin
                if (!i_axis_TVALID) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_state == HEADER && r_cnt == 16'd19 && w_bad) begin
                    w_err       = 1'b1;
                    w_state_nxt = DROP;
                end else if (w_last && w_csum_bad) begin
                    w_err       = 1'b1;
                    w_state_nxt = DROP;
                end else if (w_last) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_plen == 16'd0) ? DROP : PAYLOAD;
                end else if (r_state == HEADER && r_cnt == 16'd19) begin
                    w_state_nxt = OPTIONS;
                end
            end
            PAYLOAD: begin
                if (!i_axis_TVALID) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_fwd       = 1'b1;
                    w_state_nxt = (r_rem == 16'd1) ? DROP : PAYLOAD;
                end
            end
            DROP: if (!i_axis_TVALID) w_state_nxt = IDLE;
            default: w_state_nxt = DROP;
        endcase
    end

    always_ff @(posedge i_axis_ACLK) begin
        if (i_axis_ARESET) begin
            o_axis_TVALID  <= 1'b0;
            o_axis_TDATA   <= '0;
            o_hdr_valid    <= 1'b0;
            o_hdr_err      <= 1'b0;
            o_src_ip_addr  <= '0;
            o_dst_ip_addr  <= '0;
            o_protocol     <= 8'd0;
            o_total_length <= 16'd0;
            r_cnt          <= 16'd0;
            r_rem          <= 16'd0;
            r_ver_ihl      <= 8'd0;
            r_tl           <= 16'd0;
            r_proto        <= 8'd0;
            r_src          <= '0;
            r_dst          <= '0;
        end else begin
            o_axis_TVALID <= w_fwd;
            o_hdr_valid   <= w_accept;
            o_hdr_err     <= w_err;
            if (w_fwd) o_axis_TDATA <= i_axis_TDATA;
            if (r_state == IDLE) begin
                r_cnt     <= 16'd1;
                r_ver_ihl <= i_axis_TDATA;
            end else if (r_state == HEADER || r_state == OPTIONS) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (r_state == HEADER) begin
                if (r_cnt == 16'd2 || r_cnt == 16'd3) r_tl <= {r_tl[7:0], i_axis_TDATA};
                if (r_cnt == 16'd9) r_proto <= i_axis_TDATA;
                if (r_cnt >= 16'd12 && r_cnt <= 16'd15) r_src <= {r_src[IP_ADDR_WIDTH-DATA_WIDTH-1:0], i_axis_TDATA};
                if (r_cnt >= 16'd16 && r_cnt <= 16'd19) r_dst <= w_dst;
            end
            if (w_accept) begin
                o_src_ip_addr  <= r_src;
                o_dst_ip_addr  <= w_dst;
                o_protocol     <= r_proto;
                o_total_length <= r_tl;
                r_rem          <= w_plen;
            end else if (w_fwd) begin
                r_rem <= r_rem - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_sakebi_ipv4_packet_rx.sv
// tb_sakebi_ipv4_packet_rx: directed and randomized IPv4 packets checked against a packet-level model.
module tb_sakebi_ipv4_packet_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic [15:0] et = 16'h0800;
    logic        ds_ready = 1'b1;
    logic        o_axis_TREADY, o_axis_TVALID, o_hdr_valid, o_hdr_err;
    logic [7:0]  o_axis_TDATA, o_protocol;
    logic [31:0] o_src_ip_addr, o_dst_ip_addr;
    logic [15:0] o_total_length;

    always #5 clk = ~clk;

    sakebi_ipv4_packet_rx dut (
        .i_axis_ACLK(clk), .i_axis_ARESET(rst), .i_axis_TVALID(in_valid), .o_axis_TREADY(o_axis_TREADY),
        .i_axis_TDATA(in_data), .i_ethertype(et), .o_axis_TVALID(o_axis_TVALID), .i_axis_TREADY(ds_ready),
        .o_axis_TDATA(o_axis_TDATA), .o_src_ip_addr(o_src_ip_addr), .o_dst_ip_addr(o_dst_ip_addr),
        .o_protocol(o_protocol), .o_total_length(o_total_length), .o_hdr_valid(o_hdr_valid), .o_hdr_err(o_hdr_err)
    );

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] pkt[$], obs_beats[$], exp_beats[$];
    int hv_cnt, er_cnt, hv_cyc, beat_cyc, hdr_cyc, exp_hv, exp_err;
    logic [31:0] obs_src, obs_dst, exp_src, exp_dst;
    logic [7:0]  obs_proto, exp_proto;
    logic [15:0] obs_tl, exp_tl;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_axis_TVALID) begin
            if (beat_cyc < 0) beat_cyc = cyc;
            obs_beats.push_back(o_axis_TDATA);
        end
        if (o_hdr_valid) begin
            hv_cnt++;
            hv_cyc = cyc;
            obs_src = o_src_ip_addr;
            obs_dst = o_dst_ip_addr;
            obs_proto = o_protocol;
            obs_tl = o_total_length;
        end
        if (o_hdr_err) er_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic clear();
        obs_beats.delete();
        exp_beats.delete();
        hv_cnt = 0; er_cnt = 0; hv_cyc = -1; beat_cyc = -1; hdr_cyc = -2;
        exp_hv = 0; exp_err = 0;
    endtask

    task automatic set_csum(input int hl, input int delta);
        int s;
        logic [15:0] c;
        pkt[10] = 8'd0;
        pkt[11] = 8'd0;
        s = 0;
        for (int i = 0; i < hl; i += 2) s += {16'd0, pkt[i], pkt[i+1]};
        while (s > 'hFFFF) s = (s & 'hFFFF) + (s >>> 16);
        c = ~s[15:0];
        c = c + delta[15:0];
        pkt[10] = c[15:8];
        pkt[11] = c[7:0];
    endtask

    task automatic build(input int ihl, input int plen, input int pad, input logic [7:0] proto,
                         input logic [31:0] src, input logic [31:0] dst);
        int hl, tl;
        logic [3:0] ih;
        hl = ihl * 4;
        tl = hl + plen;
        ih = ihl[3:0];
        pkt.delete();
        pkt.push_back({4'h4, ih});
        pkt.push_back(8'($urandom));
        pkt.push_back(tl[15:8]);
        pkt.push_back(tl[7:0]);
        repeat (4) pkt.push_back(8'($urandom));
        pkt.push_back(8'($urandom_range(1, 255)));
        pkt.push_back(proto);
        pkt.push_back(8'd0);
        pkt.push_back(8'd0);
        for (int i = 3; i >= 0; i--) pkt.push_back(src[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) pkt.push_back(dst[i*8 +: 8]);
        repeat (hl - 20 + plen + pad) pkt.push_back(8'($urandom));
        set_csum(hl, 0);
    endtask

    // Expected observable result of one frame of n bytes, accumulated into exp_*
    task automatic model(input logic [15:0] e, input int n);
        int ihl, hl, tl, plen, avail;
        logic [7:0] b0;
`ifdef SAKEBI_IPV4_CSUM_CHECK_EN
        int s;
`endif
        if (e != 16'h0800) return;
        if (n < 20) begin exp_err++; return; end
        b0 = pkt[0];
        ihl = int'(b0[3:0]);
        hl = ihl * 4;
        tl = int'({pkt[2], pkt[3]});
        if (b0[7:4] != 4'd4 || ihl < 5 || tl < hl) begin exp_err++; return; end
        if (n < hl) begin exp_err++; return; end
`ifdef SAKEBI_IPV4_CSUM_CHECK_EN
        s = 0;
        for (int i = 0; i < hl; i += 2) s += {16'd0, pkt[i], pkt[i+1]};
        while (s > 'hFFFF) s = (s & 'hFFFF) + (s >>> 16);
        if (s != 'hFFFF) begin exp_err++; return; end
`endif
        exp_hv++;
        exp_src = {pkt[12], pkt[13], pkt[14], pkt[15]};
        exp_dst = {pkt[16], pkt[17], pkt[18], pkt[19]};
        exp_proto = pkt[9];
        exp_tl = tl[15:0];
        plen = tl - hl;
        avail = n - hl;
        for (int i = 0; i < plen && i < avail; i++) exp_beats.push_back(pkt[hl + i]);
        if (avail < plen) exp_err++;
    endtask

    task automatic send(input logic [15:0] e, input int n, input int gap);
        logic [7:0] b0;
        b0 = pkt[0];
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data = pkt[i];
            et = e;
            if (i == 4 * int'(b0[3:0]) - 1) hdr_cyc = cyc + 1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = 8'($urandom);
        repeat (gap - 1) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic gen_random(output logic [15:0] e, output int n);
        int k, ihl, t;
        logic [7:0] b0;
        k = $urandom_range(0, 9);
        ihl = $urandom_range(5, 8);
        build(ihl, $urandom_range(0, 16), $urandom_range(0, 6), 8'($urandom), $urandom, $urandom);
        e = 16'h0800;
        n = pkt.size();
        b0 = pkt[0];
        case (k)
            0: e = 16'h0806;
            1: pkt[0] = {4'h6, b0[3:0]};
            2: pkt[0] = {4'h4, 4'($urandom_range(0, 4))};
            3: begin
                t = $urandom_range(0, ihl * 4 - 1);
                pkt[2] = t[15:8];
                pkt[3] = t[7:0];
                set_csum(ihl * 4, 0);
            end
            4: n = $urandom_range(1, pkt.size() - 1);
            5: set_csum(ihl * 4, 1);
            default: ;
        endcase
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_axis_TREADY !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b expected 1", o_axis_TREADY); end
        checks++; if ({o_axis_TVALID, o_hdr_valid, o_hdr_err} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {o_axis_TVALID, o_hdr_valid, o_hdr_err}); end
        checks++; if ({o_src_ip_addr, o_dst_ip_addr, o_protocol, o_total_length, o_axis_TDATA} !== 96'd0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {o_src_ip_addr, o_dst_ip_addr, o_protocol, o_total_length, o_axis_TDATA}); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({o_axis_TREADY, o_axis_TVALID, o_hdr_valid, o_hdr_err} !== 4'b1000) begin errors++; $display("FAIL post_reset_idle: got %b expected 1000", {o_axis_TREADY, o_axis_TVALID, o_hdr_valid, o_hdr_err}); end
    endtask

    task automatic test_valid_packet();
        logic ok;
        clear();
        build(5, 8, 10, 8'h11, 32'hC0A80102, 32'hC0A8010A);
        pkt[1] = 8'h00; pkt[4] = 8'h00; pkt[5] = 8'h00; pkt[6] = 8'h40; pkt[7] = 8'h00; pkt[8] = 8'h40;
        for (int i = 0; i < 8; i++) pkt[20 + i] = 8'(i + 1);
        set_csum(20, 0);
        send(16'h0800, pkt.size(), 2);
        drain();
        checks++; if (hv_cnt != 1) begin errors++; $display("FAIL valid_hdr_valid: got %0d pulses expected 1", hv_cnt); end
        checks++; if (er_cnt != 0) begin errors++; $display("FAIL valid_hdr_err: got %0d pulses expected 0", er_cnt); end
        checks++; if (obs_src !== 32'hC0A80102) begin errors++; $display("FAIL valid_src: got %h expected C0A80102", obs_src); end
        checks++; if (obs_dst !== 32'hC0A8010A) begin errors++; $display("FAIL valid_dst: got %h expected C0A8010A", obs_dst); end
        checks++; if (obs_proto !== 8'h11) begin errors++; $display("FAIL valid_proto: got %h expected 11", obs_proto); end
        checks++; if (obs_tl !== 16'h001C) begin errors++; $display("FAIL valid_total_length: got %h expected 001C", obs_tl); end
        ok = (obs_beats.size() == 8);
        for (int i = 0; ok && i < 8; i++) ok = (obs_beats[i] === 8'(i + 1));
        checks++; if (!ok) begin errors++; $display("FAIL valid_payload: got %0d beats expected 8 beats 01..08", obs_beats.size()); end
        checks++; if (hv_cyc != hdr_cyc) begin errors++; $display("FAIL valid_hdr_timing: pulse cycle %0d expected %0d", hv_cyc, hdr_cyc); end
        checks++; if (beat_cyc != hv_cyc + 1) begin errors++; $display("FAIL valid_first_beat: cycle %0d expected %0d", beat_cyc, hv_cyc + 1); end
    endtask

    task automatic test_options();
        logic ok;
        clear();
        build(6, 8, 3, 8'h06, $urandom, $urandom);
        model(16'h0800, pkt.size());
        send(16'h0800, pkt.size(), 2);
        drain();
        checks++; if (hv_cnt != 1 || er_cnt != 0) begin errors++; $display("FAIL opt_pulses: got valid=%0d err=%0d expected 1/0", hv_cnt, er_cnt); end
        checks++; if (obs_tl !== 16'h0020 || obs_dst !== exp_dst || obs_src !== exp_src) begin errors++; $display("FAIL opt_fields: got tl=%h src=%h dst=%h expected 0020 %h %h", obs_tl, obs_src, obs_dst, exp_src, exp_dst); end
        ok = (obs_beats.size() == exp_beats.size()) && (exp_beats.size() == 8);
        for (int i = 0; ok && i < exp_beats.size(); i++) ok = (obs_beats[i] === exp_beats[i]);
        checks++; if (!ok) begin errors++; $display("FAIL opt_payload: got %0d beats expected 8 matching bytes 24..31", obs_beats.size()); end
        checks++; if (hv_cyc != hdr_cyc) begin errors++; $display("FAIL opt_hdr_timing: pulse cycle %0d expected %0d (byte 23 + 1)", hv_cyc, hdr_cyc); end
    endtask

    task automatic test_arp();
        clear();
        build(5, 8, 0, 8'h11, $urandom, $urandom);
        send(16'h0806, 28, 2);
        drain();
        checks++; if (hv_cnt != 0 || er_cnt != 0) begin errors++; $display("FAIL arp_pulses: got valid=%0d err=%0d expected 0/0", hv_cnt, er_cnt); end
        checks++; if (obs_beats.size() != 0) begin errors++; $display("FAIL arp_beats: got %0d beats expected 0", obs_beats.size()); end
    endtask

    task automatic test_bad_header();
        logic ok;
        for (int v = 0; v < 2; v++) begin
            clear();
            build(5, 6, 4, 8'h11, $urandom, $urandom);
            pkt[0] = (v == 0) ? 8'h65 : 8'h44;
            send(16'h0800, pkt.size(), 2);
            drain();
            checks++; if (er_cnt != 1 || hv_cnt != 0) begin errors++; $display("FAIL bad_hdr_%0d: got err=%0d valid=%0d expected 1/0", v, er_cnt, hv_cnt); end
            checks++; if (obs_beats.size() != 0) begin errors++; $display("FAIL bad_hdr_beats_%0d: got %0d beats expected 0", v, obs_beats.size()); end
        end
        clear();
        build(5, 5, 2, 8'h01, $urandom, $urandom);
        model(16'h0800, pkt.size());
        send(16'h0800, pkt.size(), 2);
        drain();
        ok = (obs_beats.size() == exp_beats.size());
        for (int i = 0; ok && i < exp_beats.size(); i++) ok = (obs_beats[i] === exp_beats[i]);
        checks++; if (hv_cnt != 1 || er_cnt != 0 || !ok) begin errors++; $display("FAIL bad_hdr_recover: got valid=%0d err=%0d beats=%0d expected 1/0/%0d", hv_cnt, er_cnt, obs_beats.size(), exp_beats.size()); end
    endtask

    task automatic test_truncation();
        clear();
        build(5, 8, 0, 8'h11, $urandom, $urandom);
        send(16'h0800, 11, 2);
        drain();
        checks++; if (er_cnt != 1 || hv_cnt != 0 || obs_beats.size() != 0) begin errors++; $display("FAIL trunc_hdr: got err=%0d valid=%0d beats=%0d expected 1/0/0", er_cnt, hv_cnt, obs_beats.size()); end
        clear();
        build(5, 10, 0, 8'h11, $urandom, $urandom);
        send(16'h0800, 24, 2);
        drain();
        checks++; if (er_cnt != 1 || hv_cnt != 1 || obs_beats.size() != 4) begin errors++; $display("FAIL trunc_payload: got err=%0d valid=%0d beats=%0d expected 1/1/4", er_cnt, hv_cnt, obs_beats.size()); end
`ifdef SAKEBI_IPV4_CSUM_CHECK_EN
        clear();
        build(5, 8, 2, 8'h11, $urandom, $urandom);
        set_csum(20, 1);
        send(16'h0800, pkt.size(), 2);
        drain();
        checks++; if (er_cnt != 1 || hv_cnt != 0 || obs_beats.size() != 0) begin errors++; $display("FAIL csum_bad: got err=%0d valid=%0d beats=%0d expected 1/0/0", er_cnt, hv_cnt, obs_beats.size()); end
`endif
    endtask

    task automatic test_reset_mid_packet();
        logic ok;
        logic [7:0] p0, p1;
        clear();
        build(5, 8, 4, 8'h11, $urandom, $urandom);
        p0 = pkt[20];
        p1 = pkt[21];
        for (int i = 0; i < pkt.size(); i++) begin
            @(posedge clk); #1;
            if (i == 23) begin
                checks++; if ({o_axis_TREADY, o_axis_TVALID, o_hdr_valid, o_hdr_err} !== 4'b1000) begin errors++; $display("FAIL midrst_strobes: got %b expected 1000", {o_axis_TREADY, o_axis_TVALID, o_hdr_valid, o_hdr_err}); end
                checks++; if ({o_src_ip_addr, o_dst_ip_addr, o_protocol, o_total_length, o_axis_TDATA} !== 96'd0) begin errors++; $display("FAIL midrst_fields: got %h expected 0", {o_src_ip_addr, o_dst_ip_addr, o_protocol, o_total_length, o_axis_TDATA}); end
            end
            rst = (i == 22);
            in_valid = 1'b1;
            in_data = pkt[i];
            et = 16'h0800;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        ok = (obs_beats.size() == 2) && (obs_beats[0] === p0) && (obs_beats[1] === p1);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_beats: got %0d beats expected 2 (payload bytes 1-2)", obs_beats.size()); end
        checks++; if (er_cnt != 0 || hv_cnt != 1) begin errors++; $display("FAIL midrst_pulses: got err=%0d valid=%0d expected 0/1", er_cnt, hv_cnt); end
        clear();
        build(5, 7, 3, 8'h06, $urandom, $urandom);
        model(16'h0800, pkt.size());
        send(16'h0800, pkt.size(), 2);
        drain();
        ok = (obs_beats.size() == exp_beats.size());
        for (int i = 0; ok && i < exp_beats.size(); i++) ok = (obs_beats[i] === exp_beats[i]);
        checks++; if (hv_cnt != 1 || er_cnt != 0 || !ok || obs_src !== exp_src) begin errors++; $display("FAIL midrst_next: got valid=%0d err=%0d beats=%0d src=%h expected 1/0/%0d/%h", hv_cnt, er_cnt, obs_beats.size(), obs_src, exp_beats.size(), exp_src); end
    endtask

    task automatic test_random();
        logic [15:0] e;
        int n;
        logic ok;
        for (int p = 0; p < 80; p++) begin
            clear();
            gen_random(e, n);
            model(e, n);
            send(e, n, $urandom_range(1, 3));
            drain();
            checks++; if (hv_cnt != exp_hv) begin errors++; $display("FAIL rnd%0d_hdr_valid: got %0d expected %0d", p, hv_cnt, exp_hv); end
            checks++; if (er_cnt != exp_err) begin errors++; $display("FAIL rnd%0d_hdr_err: got %0d expected %0d", p, er_cnt, exp_err); end
            ok = (obs_beats.size() == exp_beats.size());
            for (int i = 0; ok && i < exp_beats.size(); i++) ok = (obs_beats[i] === exp_beats[i]);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_payload: got %0d beats expected %0d (or data differs)", p, obs_beats.size(), exp_beats.size()); end
            if (exp_hv == 1) begin
                checks++; if ({obs_src, obs_dst, obs_proto, obs_tl} !== {exp_src, exp_dst, exp_proto, exp_tl}) begin errors++; $display("FAIL rnd%0d_fields: got %h expected %h", p, {obs_src, obs_dst, obs_proto, obs_tl}, {exp_src, exp_dst, exp_proto, exp_tl}); end
                checks++; if (hv_cyc != hdr_cyc) begin errors++; $display("FAIL rnd%0d_hdr_timing: got cycle %0d expected %0d", p, hv_cyc, hdr_cyc); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        int n;
        logic ok;
        clear();
        for (int p = 0; p < 8; p++) begin
            gen_random(e, n);
            if (p % 2 == 0) build(5, $urandom_range(1, 12), $urandom_range(0, 4), 8'($urandom), $urandom, $urandom);
            if (p % 2 == 0) begin e = 16'h0800; n = pkt.size(); end
            model(e, n);
            send(e, n, 1);
        end
        drain();
        checks++; if (hv_cnt != exp_hv || er_cnt != exp_err) begin errors++; $display("FAIL b2b_pulses: got valid=%0d err=%0d expected %0d/%0d", hv_cnt, er_cnt, exp_hv, exp_err); end
        ok = (obs_beats.size() == exp_beats.size());
        for (int i = 0; ok && i < exp_beats.size(); i++) ok = (obs_beats[i] === exp_beats[i]);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_payload: got %0d beats expected %0d (or data differs)", obs_beats.size(), exp_beats.size()); end
        checks++; if ({obs_src, obs_dst, obs_proto, obs_tl} !== {exp_src, exp_dst, exp_proto, exp_tl}) begin errors++; $display("FAIL b2b_fields: got %h expected %h", {obs_src, obs_dst, obs_proto, obs_tl}, {exp_src, exp_dst, exp_proto, exp_tl}); end
    endtask

    initial begin
        clear();
        test_reset();
        test_valid_packet();
        test_options();
        test_arp();
        test_bad_header();
        test_truncation();
        test_reset_mid_packet();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
